// File: rtl/pattern_pkg.sv
// Shared definitions for the pattern record interface used by
// pattern_recorder (writer) and pattern_manager (reader).
package pattern_pkg;

  localparam int TS_W  = 10;
  localparam int PAT_W = 8;
  localparam int REC_W = 18;

  typedef struct packed {
    logic [TS_W-1:0]  ts;
    logic [PAT_W-1:0] pat;
  } pattern_rec_t;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RECORD = 2'd1,
    FLUSH  = 2'd2
  } rec_state_e;

endpackage

// File: rtl/pattern_recorder_if.sv
// Record stream from pattern_recorder to a chart sink.
interface pattern_recorder_if #(
  parameter int W = pattern_pkg::REC_W
);
  // A record transfers on every rising clock edge where rec_valid && rec_ready.
  // While rec_valid is high and rec_ready is low, rec_data holds steady and
  // rec_valid stays high; only a transfer (or reset) may retire it.
  logic [W-1:0] rec_data;
  logic         rec_valid;
  logic         rec_ready;

  modport master (output rec_data, output rec_valid, input rec_ready);
  modport slave  (input rec_data, input rec_valid, output rec_ready);
endinterface

// File: rtl/record_fifo.sv
// First-word-fall-through FIFO for pattern records; head is always on dout.
module record_fifo #(
  parameter  int DEPTH = 16,
  parameter  int W     = 18,
  localparam int AW    = $clog2(DEPTH),
  localparam int CW    = $clog2(DEPTH + 1)
) (
  input  logic          clock,
  input  logic          reset_n,
  input  logic          push,
  input  logic          pop,
  input  logic [W-1:0]  din,
  output logic [W-1:0]  dout,
  output logic          full,
  output logic          empty,
  output logic [CW-1:0] count
);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          do_push;
  logic          do_pop;

  // A push into a full FIFO is accepted when the head leaves on the same edge.
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);

  assign full  = (count == CW'(DEPTH));
  assign empty = (count == '0);
  assign dout  = empty ? '0 : mem[rd_ptr];

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  end

  always_ff @(posedge clock) begin
    if (do_push) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/pattern_recorder.sv
// Samples user_input against counter10h and emits {timestamp, pattern}
// records for every change seen while recording.
module pattern_recorder
  import pattern_pkg::rec_state_e, pattern_pkg::IDLE, pattern_pkg::RECORD, pattern_pkg::FLUSH;
#(
  parameter  int DEPTH = 16,
  parameter  int TS_W  = pattern_pkg::TS_W,
  parameter  int PAT_W = pattern_pkg::PAT_W,
  localparam int CW    = $clog2(DEPTH + 1)
) (
  input  logic               clock,
  input  logic               reset_n,
  input  logic               start,
  input  logic               stop,
  input  logic [TS_W-1:0]    counter10h,
  input  logic [PAT_W-1:0]   user_input,
  pattern_recorder_if.master rec,
  output logic               busy,
  output logic               overflow,
  output logic [CW-1:0]      count,
  output rec_state_e         dbg_state
);

  localparam int RW = TS_W + PAT_W;

  logic [PAT_W-1:0] sync1;
  logic [PAT_W-1:0] sync_q;
  logic [PAT_W-1:0] last_q;
  rec_state_e       state;
  rec_state_e       state_nxt;
  logic             push;
  logic             pop;
  logic             fifo_full;
  logic             fifo_empty;
  logic [RW-1:0]    fifo_dout;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      sync1  <= '0;
      sync_q <= '0;
    end else begin
      sync1  <= user_input;
      sync_q <= sync1;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start)      state_nxt = RECORD;
      RECORD:  if (stop)       state_nxt = FLUSH;
      FLUSH:   if (fifo_empty) state_nxt = IDLE;
      default:                 state_nxt = IDLE;
    endcase
  end

  always_comb begin
    busy          = (state != IDLE);
    dbg_state     = state;
    push          = (state == RECORD) && (sync_q != last_q) && !stop;
    rec.rec_valid = !fifo_empty;
    rec.rec_data  = fifo_dout;
    pop           = !fifo_empty && rec.rec_ready;
  end

  // Starting takes the current keys as the baseline; a dropped record
  // still advances the baseline so the next change is measured from it.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      last_q   <= '0;
      overflow <= 1'b0;
    end else if (state == IDLE && start) begin
      last_q   <= sync_q;
      overflow <= 1'b0;
    end else if (push) begin
      last_q <= sync_q;
      if (fifo_full && !pop) overflow <= 1'b1;
    end
  end

  record_fifo #(.DEPTH(DEPTH), .W(RW)) u_fifo (
    .clock   (clock),
    .reset_n (reset_n),
    .push    (push),
    .pop     (pop),
    .din     ({counter10h, sync_q}),
    .dout    (fifo_dout),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .count   (count)
  );

endmodule

// File: tb/tb_pattern_recorder.sv
// Directed test-plan scenarios plus randomized traffic, checked against a
// queue-based model of the recorder's rules.
module tb_pattern_recorder;
  import pattern_pkg::*;

  localparam int DEPTH = 16;
  localparam int CW    = $clog2(DEPTH + 1);

  logic          clock = 1'b0;
  logic          reset_n;
  logic          start;
  logic          stop;
  logic [9:0]    counter10h;
  logic [7:0]    user_input;
  logic          busy;
  logic          overflow;
  logic [CW-1:0] count;
  rec_state_e    dbg_state;

  pattern_recorder_if rec_if ();

  pattern_recorder #(.DEPTH(DEPTH)) dut (
    .clock      (clock),
    .reset_n    (reset_n),
    .start      (start),
    .stop       (stop),
    .counter10h (counter10h),
    .user_input (user_input),
    .rec        (rec_if),
    .busy       (busy),
    .overflow   (overflow),
    .count      (count),
    .dbg_state  (dbg_state)
  );

  always #5 clock = ~clock;

  int total = 0;
  int bad   = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h want=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: mode 0 idle, 1 recording, 2 flushing; exp_q is the FIFO.
  int          m_mode;
  logic [7:0]  m_s1, m_sq, m_last;
  bit          m_ovf;
  logic [17:0] exp_q[$];

  task automatic model_reset();
    m_mode = 0;
    m_s1   = '0;
    m_sq   = '0;
    m_last = '0;
    m_ovf  = 1'b0;
    exp_q.delete();
  endtask

  task automatic model_edge();
    int sz;
    bit pop_now, push_now;
    sz       = exp_q.size();
    pop_now  = (sz > 0) && rec_if.rec_ready;
    push_now = (m_mode == 1) && (m_sq != m_last) && !stop;
    if (pop_now) void'(exp_q.pop_front());
    if (push_now) begin
      if (sz < DEPTH || pop_now) exp_q.push_back({counter10h, m_sq});
      else m_ovf = 1'b1;
      m_last = m_sq;
    end
    case (m_mode)
      0: if (start) begin m_last = m_sq; m_ovf = 1'b0; m_mode = 1; end
      1: if (stop) m_mode = 2;
      default: if (sz == 0) m_mode = 0;
    endcase
    m_sq = m_s1;
    m_s1 = user_input;
  endtask

  task automatic check_outputs();
    int sz;
    sz = exp_q.size();
    check_eq("count", count, sz);
    check_eq("valid", rec_if.rec_valid, sz != 0);
    check_eq("busy", busy, m_mode != 0);
    check_eq("overflow", overflow, m_ovf);
    check_eq("data", rec_if.rec_data, (sz != 0) ? exp_q[0] : 18'h0);
  endtask

  task automatic cycle();
    @(posedge clock);
    model_edge();
    #1;
    check_outputs();
    @(negedge clock);
  endtask

  task automatic cycles(input int n);
    for (int i = 0; i < n; i++) cycle();
  endtask

  task automatic pulse_start();
    start = 1'b1; cycle(); start = 1'b0;
  endtask

  task automatic pulse_stop();
    stop = 1'b1; cycle(); stop = 1'b0;
  endtask

  initial begin
    reset_n = 1'b0;
    start = 1'b0; stop = 1'b0;
    counter10h = '0; user_input = '0;
    rec_if.rec_ready = 1'b0;
    model_reset();
    @(negedge clock); @(negedge clock);
    check_outputs();
    check_eq("reset_state", dbg_state, IDLE);
    reset_n = 1'b1;
    cycles(2);

    // Basic capture with fixed timestamp 20
    counter10h = 10'd20; rec_if.rec_ready = 1'b1;
    pulse_start();
    cycles(2);
    user_input = 8'h05;
    cycle();
    cycle();
    check_eq("cap_e1_valid", rec_if.rec_valid, 1'b0);
    cycle();
    check_eq("cap_e2_valid", rec_if.rec_valid, 1'b1);
    check_eq("cap_data", rec_if.rec_data, {10'd20, 8'h05});
    cycle();
    pulse_stop();
    cycles(3);

    // Baseline load: held keys at start are not a change
    user_input = 8'h03; rec_if.rec_ready = 1'b0;
    cycles(3);
    pulse_start();
    cycles(5);
    check_eq("base_none", count, 0);
    counter10h = 10'd33;
    user_input = 8'h00;
    cycles(4);
    check_eq("base_cnt", count, 1);
    check_eq("base_pat", rec_if.rec_data, {10'd33, 8'h00});
    rec_if.rec_ready = 1'b1;
    cycle();
    pulse_stop();
    cycles(3);

    // Overflow: DEPTH+2 changes with the sink stalled
    pulse_start();
    rec_if.rec_ready = 1'b0;
    for (int i = 0; i < DEPTH + 2; i++) begin
      user_input = 8'(i + 1);
      counter10h = 10'(100 + i);
      cycle();
    end
    cycles(3);
    check_eq("ovf_count", count, DEPTH);
    check_eq("ovf_flag", overflow, 1'b1);
    check_eq("ovf_head", rec_if.rec_data[7:0], 8'h01);
    rec_if.rec_ready = 1'b1;
    cycles(DEPTH + 2);
    check_eq("ovf_drained", count, 0);
    pulse_stop();
    cycles(3);

    // Full boundary: push and pop on the same edge while full
    pulse_start();
    rec_if.rec_ready = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      user_input = 8'(8'h40 + i);
      counter10h = 10'(200 + i);
      cycle();
    end
    cycles(3);
    check_eq("fb_full", count, DEPTH);
    user_input = 8'h80;
    cycle();
    cycle();
    rec_if.rec_ready = 1'b1;
    cycle();
    rec_if.rec_ready = 1'b0;
    check_eq("fb_count", count, DEPTH);
    check_eq("fb_ovf", overflow, 1'b0);
    check_eq("fb_head", rec_if.rec_data[7:0], 8'h41);
    rec_if.rec_ready = 1'b1;
    pulse_stop();
    cycles(DEPTH + 4);
    check_eq("fb_idle", busy, 1'b0);

    // Flush with timestamp wrap
    rec_if.rec_ready = 1'b0;
    pulse_start();
    counter10h = 10'h3FF; user_input = 8'h11;
    cycles(3);
    counter10h = 10'h000; user_input = 8'h22;
    cycles(3);
    check_eq("wrap_cnt", count, 2);
    check_eq("wrap_ts0", rec_if.rec_data, {10'h3FF, 8'h11});
    pulse_stop();
    user_input = 8'h33;
    rec_if.rec_ready = 1'b1;
    cycle();
    check_eq("wrap_ts1", rec_if.rec_data, {10'h000, 8'h22});
    check_eq("flush_busy1", busy, 1'b1);
    rec_if.rec_ready = 1'b0;
    cycle();
    check_eq("flush_busy2", busy, 1'b1);
    rec_if.rec_ready = 1'b1;
    cycle();
    cycle();
    check_eq("flush_idle", busy, 1'b0);
    cycles(4);
    check_eq("no_post_stop", count, 0);

    // Asynchronous reset with records queued
    rec_if.rec_ready = 1'b0;
    pulse_start();
    for (int i = 0; i < 3; i++) begin
      user_input = 8'(8'h51 + i);
      cycle();
    end
    cycles(3);
    check_eq("rst_pre", count, 3);
    #2 reset_n = 1'b0;
    #1;
    check_eq("rst_valid", rec_if.rec_valid, 1'b0);
    check_eq("rst_count", count, 0);
    check_eq("rst_busy", busy, 1'b0);
    check_eq("rst_data", rec_if.rec_data, 18'h0);
    model_reset();
    @(negedge clock); @(negedge clock);
    reset_n = 1'b1;
    rec_if.rec_ready = 1'b1;
    cycles(5);
    check_eq("rst_stale", rec_if.rec_valid, 1'b0);

    // Randomized traffic with alternating sink pressure
    for (int i = 0; i < 3000; i++) begin
      start = ($urandom_range(0, 19) == 0);
      stop  = ($urandom_range(0, 39) == 0);
      if ($urandom_range(0, 2) == 0)
        user_input = ($urandom_range(0, 3) == 0) ? 8'h00 : 8'($urandom_range(0, 255));
      if (((i / 300) % 2) == 0) rec_if.rec_ready = ($urandom_range(0, 3) != 0);
      else                      rec_if.rec_ready = ($urandom_range(0, 5) == 0);
      if ($urandom_range(0, 1) == 0) counter10h = counter10h + 10'd1;
      cycle();
    end
    start = 1'b0; stop = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/pattern_recorder.md
# pattern_recorder

Captures live player input as a chart and emits it as 18-bit timestamped pattern records, {timestamp[9:0], pattern[7:0]}. These are the same records that pattern_manager consumes on `pattern_with_timestamp`. The block is the writer end of that record interface. It sits beside input_manager, samples `user_input` against the `counter10h` game time, and buffers records in a FIFO. A valid/ready handshake drains the FIFO to a downstream sink such as a chart RAM writer or a host link.

## Interface
Parameters:
- `DEPTH`, 16: FIFO depth in records; must be a power of 2, minimum 2.
- `TS_W`, 10: timestamp width; matches `counter10h`.
- `PAT_W`, 8: pattern width; matches `user_input`.

Ports:
- `clock` in 1: single clock; all logic on its rising edge.
- `reset_n` in 1: reset, asynchronous assert and active-low.
- `start` in 1: single-cycle pulse; begin recording.
- `stop` in 1: single-cycle pulse; end recording.
- `counter10h` in TS_W: current game time.
- `user_input` in PAT_W: raw, asynchronous key lines.
- `rec_data` out TS_W+PAT_W: head record, {timestamp, pattern}.
- `rec_valid` out 1: `rec_data` is valid.
- `rec_ready` in 1: sink accepts the record.
- `busy` out 1: state is not IDLE.
- `overflow` out 1: sticky; at least one record was dropped.
- `count` out $clog2(DEPTH+1): number of records held in the FIFO.

## Operation
- Input path:
  - 2-flop synchronizer on `user_input`, giving `sync_q`.
  - A `last_q` register holds the last recorded pattern.
- States and transitions:
  - IDLE → RECORD on `start`. `last_q` is loaded with `sync_q`, no record is emitted, and `overflow` is cleared. `stop` is ignored in IDLE.
  - RECORD → FLUSH on `stop`. `start` is ignored in RECORD.
  - FLUSH → IDLE when the FIFO is empty; in FLUSH, `start` and `stop` are both ignored.
- Push condition: RECORD, `sync_q != last_q`, and no `stop` in the same cycle.
  - The pushed record is {`counter10h`, `sync_q`}.
  - `last_q` is updated to `sync_q` on that edge.
- Every change produces one record, including release to 8'h00. Several changes within one `counter10h` value produce several records with equal timestamps.
- Timestamp wraps naturally: 10'h3FF is followed by 10'h000 with no special handling.
- FIFO full on a push:
  - If a pop happens in the same cycle, the push succeeds and `count` is unchanged.
  - Otherwise the record is dropped, `overflow` is set, and `last_q` still updates.
- FIFO empty with a push and no pop: `count` becomes 1 and `rec_valid` rises on the next cycle.
- Handshake:
  - A pop happens when `rec_valid && rec_ready`.
  - `rec_data` must stay stable while `rec_valid` is high and `rec_ready` is low.
  - `rec_valid` never drops without a pop, except on reset.
- Reset (mid-operation included):
  - State returns to IDLE and FIFO contents are discarded.
  - `rec_valid`=0, `rec_data`=0, `busy`=0, `overflow`=0, `count`=0, `last_q`=0, synchronizer=0.

## Timing
- Input change to record:
  - `user_input` changes before edge E0.
  - `sync_q` updates at edge E1.
  - The push is written at edge E2, using the `counter10h` value sampled at E2.
  - `rec_valid` is high after E2 if the FIFO was empty.
- FIFO is first-word-fall-through: the head record is visible on `rec_data` with no extra read latency.
- Throughput: one push and one pop per cycle.
- `count` and `busy` are registered and reflect the state after each edge.

## Structure
- Shared package `pattern_pkg` (shared with pattern_manager) holds:
  - constants TS_W, PAT_W, REC_W = 18;
  - `pattern_rec_t`, a packed struct {ts, pat};
  - `rec_state_e` enum {IDLE, RECORD, FLUSH}.
- Sub-module `record_fifo` provides a FWFT FIFO (DEPTH × REC_W) with `push`, `pop`, `full`, `empty` and `count`.
- pattern_recorder contains the synchronizer, change detect and FSM.

## Test plan
- Basic capture:
  - Stimulus: `start`, then `user_input` 00→05 while `counter10h`=10'd20 is held, `rec_ready`=1.
  - Required: one record 18'h{14,05} accepted, with `rec_valid` high exactly 2 edges after the change.
- Baseline load:
  - Stimulus: `user_input`=8'h03 before `start`, held constant.
  - Required: no record. Then a change to 8'h00 gives exactly one record with pattern 8'h00.
- Overflow:
  - Stimulus: `rec_ready`=0, DEPTH+2 changes.
  - Required: `count`=DEPTH and `overflow`=1. Draining yields DEPTH records in order; the first DEPTH changes are kept.
- Full boundary:
  - Stimulus: a push and a pop in the same cycle while full.
  - Required: `count` stays DEPTH, `overflow` stays 0, the head advances.
- Flush and wrap:
  - Stimulus: change at `counter10h`=3FF and 000, then `stop` with 2 records queued, `rec_ready` toggling.
  - Required: records carry ts 3FF then 000 in that order, `busy` stays 1 until the last pop and then drops to 0, and changes after `stop` are not recorded.
- Reset mid-operation:
  - Stimulus: assert `reset_n`=0 asynchronously with 3 records queued.
  - Required: immediately `rec_valid`=0, `count`=0, `busy`=0, and no stale record after release.
